// File: rtl/gpu_matmul_pkg.sv
// rtl/gpu_matmul_pkg.sv - shared types, constants and element math for the matmul lanes
// GPU_MATMUL_SAT_EN selects saturating (defined) or wrapping (undefined) 8-bit reduction.
package gpu_matmul_pkg;

    localparam int ELEM_W       = 8;
    localparam int WORD_W       = 4 * ELEM_W;
    localparam int MATMUL_STEPS = 4;
    localparam int IDX_W        = 2;
    localparam int SUM_W        = 2 * ELEM_W + 1;

    // Bit offsets of each element inside a packed 2x2 word
    localparam int E00_LSB = 0;
    localparam int E01_LSB = ELEM_W;
    localparam int E10_LSB = 2 * ELEM_W;
    localparam int E11_LSB = 3 * ELEM_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } lane_state_t;

    function automatic logic [ELEM_W-1:0] reduce_sum(input logic signed [SUM_W-1:0] s);
`ifdef GPU_MATMUL_SAT_EN
        if (s > 17'sd127) begin
            return 8'h7F;
        end else if (s < -17'sd128) begin
            return 8'h80;
        end else begin
            return s[ELEM_W-1:0];
        end
`else
        return s[ELEM_W-1:0];
`endif
    endfunction

    // idx[1] selects the row of A, idx[0] the column of B
    function automatic logic [ELEM_W-1:0] calc_elem(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input logic [IDX_W-1:0]  idx
    );
        logic        [ELEM_W-1:0]   a_i0;
        logic        [ELEM_W-1:0]   a_i1;
        logic        [ELEM_W-1:0]   b_0j;
        logic        [ELEM_W-1:0]   b_1j;
        logic signed [2*ELEM_W-1:0] p0;
        logic signed [2*ELEM_W-1:0] p1;
        logic signed [SUM_W-1:0]    s;
        a_i0 = idx[1] ? a[E10_LSB +: ELEM_W] : a[E00_LSB +: ELEM_W];
        a_i1 = idx[1] ? a[E11_LSB +: ELEM_W] : a[E01_LSB +: ELEM_W];
        b_0j = idx[0] ? b[E01_LSB +: ELEM_W] : b[E00_LSB +: ELEM_W];
        b_1j = idx[0] ? b[E11_LSB +: ELEM_W] : b[E10_LSB +: ELEM_W];
        p0 = $signed({{ELEM_W{a_i0[ELEM_W-1]}}, a_i0}) * $signed({{ELEM_W{b_0j[ELEM_W-1]}}, b_0j});
        p1 = $signed({{ELEM_W{a_i1[ELEM_W-1]}}, a_i1}) * $signed({{ELEM_W{b_1j[ELEM_W-1]}}, b_1j});
        s  = $signed({p0[2*ELEM_W-1], p0}) + $signed({p1[2*ELEM_W-1], p1});
        return reduce_sum(s);
    endfunction

endpackage

// File: rtl/gpu_matmul_lane.sv
// rtl/gpu_matmul_lane.sv - one 2x2 int8 matmul lane: edge detect, sequential FSM, sticky drop flag
// Reduction mode follows GPU_MATMUL_SAT_EN through gpu_matmul_pkg.
module gpu_matmul_lane
    import gpu_matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_matrix_a,
    input  logic [WORD_W-1:0] i_matrix_b,
    output logic              o_busy,
    output logic [WORD_W-1:0] o_matrix_c,
    output logic              o_done,
    output logic              o_start_dropped
);

    lane_state_t       r_state;
    lane_state_t       w_state_nxt;
    logic              r_start_q;
    logic              w_rise;
    logic              w_launch;
    logic              w_finish;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic [WORD_W-1:0] r_shadow;
    logic [WORD_W-1:0] r_c;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_dropped;
    logic [ELEM_W-1:0] w_elem;

    assign w_rise = i_start & ~r_start_q;
    assign w_elem = calc_elem(r_a, r_b, r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_idx == IDX_W'(MATMUL_STEPS - 1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_shadow  <= '0;
            r_c       <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_start_q <= i_start;
            r_done    <= 1'b0;
            if (w_launch) begin
                r_a    <= i_matrix_a;
                r_b    <= i_matrix_b;
                r_idx  <= '0;
                r_busy <= 1'b1;
            end
            if (r_state == ST_CALC) begin
                r_shadow[{r_idx, 3'b000} +: ELEM_W] <= w_elem;
                r_idx <= r_idx + 1'b1;
                // A rising edge during CALC is never queued, only recorded
                if (w_rise) begin
                    r_dropped <= 1'b1;
                end
            end
            if (w_finish) begin
                r_c    <= {w_elem, r_shadow[E11_LSB-1:0]};
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_busy          = r_busy;
    assign o_matrix_c      = r_c;
    assign o_done          = r_done;
    assign o_start_dropped = r_dropped;

endmodule

// File: rtl/gpu_matmul_array.sv
// rtl/gpu_matmul_array.sv - bank of NUM_UNITS independent 2x2 int8 matmul lanes on the custom-0 path
// Saturating element reduction when GPU_MATMUL_SAT_EN is defined, wrapping otherwise.
module gpu_matmul_array
    import gpu_matmul_pkg::*;
#(
    parameter int NUM_UNITS = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_UNITS-1:0]              unit_start,
    input  logic [NUM_UNITS-1:0][WORD_W-1:0]  matrix_a,
    input  logic [NUM_UNITS-1:0][WORD_W-1:0]  matrix_b,
    output logic [NUM_UNITS-1:0]              unit_busy,
    output logic [NUM_UNITS-1:0][WORD_W-1:0]  matrix_c,
    output logic [NUM_UNITS-1:0]              unit_done,
    output logic [NUM_UNITS-1:0]              start_dropped
);

    genvar g;
    generate
        for (g = 0; g < NUM_UNITS; g++) begin : g_lane
            gpu_matmul_lane u_lane (
                .clk             (clk),
                .rst_n           (rst_n),
                .i_start         (unit_start[g]),
                .i_matrix_a      (matrix_a[g]),
                .i_matrix_b      (matrix_b[g]),
                .o_busy          (unit_busy[g]),
                .o_matrix_c      (matrix_c[g]),
                .o_done          (unit_done[g]),
                .o_start_dropped (start_dropped[g])
            );
        end
    endgenerate

endmodule
